// File: rtl/transmitter_awgn_receiver.sv
// Four-channel BPSK link model: +/-AMP transmitter, LFSR-driven approximately-Gaussian
// noise channel with saturation, and hard-decision receiver in a fixed 3-stage pipeline.
module transmitter_awgn_receiver #(
  parameter logic signed [15:0] AMP         = 16'sd8192,
  parameter int unsigned        NOISE_SHIFT = 3,
  parameter logic        [31:0] SEED1       = 32'h1234_5678,
  parameter logic        [31:0] SEED2       = 32'h9ABC_DEF1,
  parameter logic        [31:0] SEED3       = 32'h0F1E_2D3C,
  parameter logic        [31:0] SEED4       = 32'hA5A5_5A5B
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        noise_off,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic [15:0] in3,
  input  logic [15:0] in4,
  output logic [15:0] out1,
  output logic [15:0] out2,
  output logic [15:0] out3,
  output logic [15:0] out4
);

  localparam logic [31:0] Taps = 32'h8020_0003;
  localparam logic [31:0] Seeds [4] = '{SEED1, SEED2, SEED3, SEED4};

  // Only the sign bit of each symbol word carries information.
  logic [3:0] sign_w;
  logic       unused_in;
  assign sign_w    = {in4[15], in3[15], in2[15], in1[15]};
  assign unused_in = ^{in1[14:0], in2[14:0], in3[14:0], in4[14:0]};

  logic        [31:0] lfsr_q [4];
  logic        [31:0] lfsr_d [4];
  logic signed [15:0] raw    [4];
  logic signed [15:0] noise  [4];
  logic signed [15:0] nz     [4];
  logic signed [16:0] sum    [4];
  logic signed [15:0] tx_q   [4];
  logic signed [15:0] rx_q   [4];
  logic signed [15:0] rx_d   [4];
  logic        [15:0] out_q  [4];
  logic               v1_q, v2_q;

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      lfsr_d[c] = {1'b0, lfsr_q[c][31:1]} ^ (lfsr_q[c][0] ? Taps : 32'h0);
      raw[c]    = {{8{lfsr_q[c][7]}},  lfsr_q[c][7:0]}
                + {{8{lfsr_q[c][15]}}, lfsr_q[c][15:8]}
                + {{8{lfsr_q[c][23]}}, lfsr_q[c][23:16]}
                + {{8{lfsr_q[c][31]}}, lfsr_q[c][31:24]};
      noise[c]  = raw[c] <<< NOISE_SHIFT;
      nz[c]     = noise_off ? 16'sd0 : noise[c];
      sum[c]    = {tx_q[c][15], tx_q[c]} + {nz[c][15], nz[c]};
      // Saturate when the 17-bit sum leaves the 16-bit range.
      if (sum[c][16] != sum[c][15]) begin
        rx_d[c] = sum[c][16] ? 16'sh8000 : 16'sh7FFF;
      end else begin
        rx_d[c] = sum[c][15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      for (int c = 0; c < 4; c++) begin
        lfsr_q[c] <= Seeds[c];
        tx_q[c]   <= 16'sd0;
        rx_q[c]   <= 16'sd0;
        out_q[c]  <= 16'h0000;
      end
    end else begin
      v1_q <= 1'b1;
      v2_q <= v1_q;
      for (int c = 0; c < 4; c++) begin
        lfsr_q[c] <= lfsr_d[c];
        tx_q[c]   <= sign_w[c] ? -AMP : AMP;
        rx_q[c]   <= rx_d[c];
        if (!v2_q) begin
          out_q[c] <= 16'h0000;
        end else begin
          out_q[c] <= rx_q[c][15] ? 16'h8000 : 16'h0001;
        end
      end
    end
  end

  assign out1 = out_q[0];
  assign out2 = out_q[1];
  assign out3 = out_q[2];
  assign out4 = out_q[3];

endmodule

// File: tb/tb_transmitter_awgn_receiver.sv
// Scoreboard bench: three builds (NOISE_SHIFT 3, 6, 12) driven in lockstep; a reference
// model predicts every output word per edge and a monitor compares after each edge.
module tb_transmitter_awgn_receiver;

  typedef logic [2:0][3:0][15:0] exp_t;

  localparam logic [31:0] Seeds [4] = '{32'h1234_5678, 32'h9ABC_DEF1, 32'h0F1E_2D3C,
                                        32'hA5A5_5A5B};
  localparam int Shifts [3] = '{3, 6, 12};
  localparam int Amp = 8192;

  logic        clk = 1'b0;
  logic        reset, noise_off;
  logic [15:0] in1, in2, in3, in4;
  logic [15:0] dout [3][4];

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q [$];

  // Reference model state: edges since reset, LFSR per channel, 1- and 2-edge histories.
  int          n_edge;
  logic [31:0] lfsr_m [4];
  logic [15:0] in_h1 [4];
  logic [15:0] in_h2 [4];
  bit          noff_h1;
  int          noise_h1 [3][4];

  always #5 clk = ~clk;

  transmitter_awgn_receiver u_dut3 (
    .clk(clk), .reset(reset), .noise_off(noise_off),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .out1(dout[0][0]), .out2(dout[0][1]), .out3(dout[0][2]), .out4(dout[0][3])
  );

  transmitter_awgn_receiver #(.NOISE_SHIFT(6)) u_dut6 (
    .clk(clk), .reset(reset), .noise_off(noise_off),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .out1(dout[1][0]), .out2(dout[1][1]), .out3(dout[1][2]), .out4(dout[1][3])
  );

  transmitter_awgn_receiver #(.NOISE_SHIFT(12)) u_dut12 (
    .clk(clk), .reset(reset), .noise_off(noise_off),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .out1(dout[2][0]), .out2(dout[2][1]), .out3(dout[2][2]), .out4(dout[2][3])
  );

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  // Byte sum scaled by 2^sh, then wrapped to a 16-bit signed value.
  function automatic int noise_of(input logic [31:0] s, input int sh);
    int          raw;
    int          v;
    logic [15:0] w;
    raw = $signed(s[7:0]) + $signed(s[15:8]) + $signed(s[23:16]) + $signed(s[31:24]);
    v   = raw * (1 << sh);
    w   = v[15:0];
    return int'($signed(w));
  endfunction

  // Sign of the true received value decides; saturation never flips a sign.
  function automatic logic [15:0] decide(input logic [15:0] w, input bit noff, input int nse);
    int r;
    r = (w[15] ? -Amp : Amp) + (noff ? 0 : nse);
    return (r < 0) ? 16'h8000 : 16'h0001;
  endfunction

  task automatic step(input bit rst, input bit noff, input logic [15:0] a0,
                      input logic [15:0] a1, input logic [15:0] a2, input logic [15:0] a3);
    logic [15:0] cur [4];
    exp_t        e;
    cur = '{a0, a1, a2, a3};
    @(negedge clk);
    reset = rst; noise_off = noff;
    in1 = a0; in2 = a1; in3 = a2; in4 = a3;
    @(posedge clk);
    e = '0;
    if (rst) begin
      n_edge = 0;
      for (int c = 0; c < 4; c++) lfsr_m[c] = Seeds[c];
    end else begin
      n_edge++;
      for (int b = 0; b < 3; b++)
        for (int c = 0; c < 4; c++)
          e[b][c] = (n_edge >= 3) ? decide(in_h2[c], noff_h1, noise_h1[b][c]) : 16'h0000;
      for (int c = 0; c < 4; c++) begin
        in_h2[c] = in_h1[c];
        in_h1[c] = cur[c];
        for (int b = 0; b < 3; b++) noise_h1[b][c] = noise_of(lfsr_m[c], Shifts[b]);
        lfsr_m[c] = lfsr_next(lfsr_m[c]);
      end
      noff_h1 = noff;
    end
    exp_q.push_back(e);
  endtask

  task automatic run_all(input int cycles, input bit noff, input logic [15:0] w);
    for (int i = 0; i < cycles; i++) step(1'b0, noff, w, w, w, w);
  endtask

  // Monitor: one expected vector per edge, compared 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      for (int b = 0; b < 3; b++)
        for (int c = 0; c < 4; c++) begin
          n_cmp++;
          if (dout[b][c] !== e[b][c]) begin
            n_err++;
            $display("FAIL out%0d shift%0d t=%0t: got %h want %h",
                     c + 1, Shifts[b], $time, dout[b][c], e[b][c]);
          end
        end
    end
  end

  initial begin
    logic [15:0] r [4];
    reset = 1'b1; noise_off = 1'b1;
    in1 = 16'hxxxx; in2 = 16'hxxxx; in3 = 16'hxxxx; in4 = 16'hxxxx;
    step(1'b1, 1'b1, 16'hxxxx, 16'hxxxx, 16'hxxxx, 16'hxxxx);
    step(1'b1, 1'b1, 16'hxxxx, 16'hxxxx, 16'hxxxx, 16'hxxxx);
    run_all(200, 1'b1, 16'h0001);
    run_all(10, 1'b1, 16'h8000);
    for (int i = 0; i < 1000; i++) step(1'b0, 1'b0, 16'h8000, 16'h0001, 16'h8000, 16'h0001);
    run_all(6, 1'b1, 16'h7FFF);
    run_all(6, 1'b0, 16'h0000);
    run_all(6, 1'b0, 16'hFFFF);
    // Mid-stream reset: the noise sequence must restart from the seeds.
    run_all(50, 1'b0, 16'h0001);
    step(1'b1, 1'b0, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
    run_all(50, 1'b0, 16'h0001);
    run_all(5, 1'b1, 16'h0001);
    run_all(20, 1'b0, 16'h0001);
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 4; c++) r[c] = 16'($urandom);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0), r[0], r[1], r[2], r[3]);
    end
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/transmitter_awgn_receiver.md
Name: transmitter_awgn_receiver

Overview:
Four-channel BPSK link model: transmitter, additive noise channel and receiver, with one clock and a fixed pipeline.
- Each channel maps an input symbol word to a ±AMP baseband sample.
- The sample gets pseudo-random approximately-Gaussian noise, which can be disabled.
- A hard decision reproduces the symbol word at the output.
- Used as a self-contained link-level test fixture for noise-filter experiments.

Parameters:
AMP, 16'sd8192, transmit amplitude (signed, Q1.14 = 0.5)
NOISE_SHIFT, 3, left shift applied to the raw noise sum (noise scale)
SEED1, 32'h1234_5678, LFSR reset seed, channel 1 (must be nonzero)
SEED2, 32'h9ABC_DEF1, LFSR reset seed, channel 2
SEED3, 32'h0F1E_2D3C, LFSR reset seed, channel 3
SEED4, 32'hA5A5_5A5B, LFSR reset seed, channel 4

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
noise_off  in  1  1 = channel noise forced to zero
in1..in4  in  16 each  transmit symbol words; bit15=0 → +1, bit15=1 → −1; bits 14:0 ignored
out1..out4  out  16 each  decided symbol words: 16'h0001 (+1), 16'h8000 (−1), 16'h0000 while invalid

Behaviour:
- Reset (sampled high at clk edge):
  - all pipeline registers and outputs cleared to 16'h0000;
  - valid shift register cleared;
  - each LFSR loads its SEEDn.
  - Reset asserted mid-operation takes effect on the next edge and discards in-flight data.
- Channels are independent and identical apart from their LFSR seed.
- Stage 1 (transmit): tx_n <= in_n[15] ? −AMP : +AMP. This stage registers in every non-reset cycle; v1 <= 1.
- Noise generation:
  - Each channel has a 32-bit Galois LFSR with taps 32'h8020_0003, advanced once per non-reset cycle.
  - raw = sum of the four signed 8-bit bytes of the current LFSR state, sign-extended to 16 bits (range −512..508).
  - noise = raw <<< NOISE_SHIFT, computed in 16-bit signed.
  - Defaults give −4096..4064.
- Stage 2 (channel):
  - rx_n <= sat16(tx_n + (noise_off ? 0 : noise_n)), with the add at 17 bits and the result saturated to [−32768, 32767].
  - v2 <= v1.
  - noise_off is sampled in this stage, for the sample entering stage 2.
- Stage 3 (receiver): out_n <= !v2 ? 16'h0000 : (rx_n < 0 ? 16'h8000 : 16'h0001). A tie (rx_n == 0) decides +1.
- Latency:
  - in_n sampled at edge k appears on out_n after edge k+2, i.e. 3 register stages.
  - Throughput is one symbol per cycle per channel.
- After reset release, outputs stay 16'h0000 for the first 2 edges, then become valid and stay valid.
- With default parameters, |noise| < AMP, so the decision is always error-free. Larger NOISE_SHIFT permits bit errors; this is intended.
- Inputs carrying X during reset must not corrupt state after reset (stage 1 is overwritten).
- No handshake, no stall, no backpressure.

Test Plan:
- Reset 2 cycles with noise_off=1, then all in=16'h0001 for 200 cycles → all out=16'h0000 until valid, then 16'h0001 from the third edge after the inputs are applied, stable.
- noise_off=1, switch all in to 16'h8000 → all out=16'h8000 exactly 3 edges later; the cycle before still reads 16'h0001.
- noise_off=0, in1/in3=16'h8000 and in2/in4=16'h0001 for 1000 cycles → outputs match inputs with 3-cycle delay and zero errors (default NOISE_SHIFT).
- Non-canonical words: in=16'h7FFF, 16'h0000, 16'hFFFF → out=16'h0001, 16'h0001, 16'h8000 respectively.
- Reset asserted mid-stream for 1 cycle → next edge all out=16'h0000, refill takes 2 more edges. LFSR sequence restarts: the noise on stage-2 samples repeats the post-first-reset sequence. Check via a NOISE_SHIFT=12 build, where the error pattern repeats identically.
- NOISE_SHIFT=6 build, noise_off=0, constant +1 input → some out=16'h8000 errors occur. Toggle noise_off=1 → errors cease from the 2nd edge after the toggle.
